trigger_capture_ctrl: RTL and testbench
=======================================

Name: trigger_capture_ctrl

Overview:
Sequences sample capture for one oscilloscope channel: arms, detects a level-crossing trigger on the XADC sample stream, and writes one decimated frame of DEPTH samples into a double-buffered display RAM. The VGA side reads the bank selected by disp_bank while the write side fills the other bank. Banks swap only on frame completion, so the display never shows a torn frame. One instance per channel sits between the XADC sample stream and the ch1/ch2 frame buffers.

Parameters:
DATA_W, 10, sample width (matches display Y range)
DEPTH, 640, samples per frame (one per display column)
ADDR_W, 10, write address width; must satisfy 2**ADDR_W >= DEPTH
DECIM_W, 8, width of decimation control
AUTO_TIMEOUT, 2_000_000, clk cycles in WAIT_TRIG before auto-trigger (used only with AUTO_TRIG_EN)

Ports:
clk  input  1  system clock, 100 MHz domain
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = acquire, 0 = stop/abort
single  input  1  1 = stop after one frame, 0 = continuous
sample_valid  input  1  one-cycle strobe per new sample
sample  input  DATA_W  sample value, valid with sample_valid
trig_level  input  DATA_W  trigger threshold
trig_falling  input  1  0 = rising-edge trigger, 1 = falling-edge trigger
decim  input  DECIM_W  keep every (decim+1)th sample during capture
force_trig  input  1  pulse; trigger on the next sample regardless of level
auto_mode  input  1  enables auto-trigger timeout (AUTO_TRIG_EN only)
wr_en  output  1  frame RAM write enable
wr_bank  output  1  bank being written; always ~disp_bank
wr_addr  output  ADDR_W  frame RAM address
wr_data  output  DATA_W  frame RAM data
disp_bank  output  1  bank the display reads
frame_done  output  1  one-cycle pulse on frame completion
busy  output  1  high in ARM, WAIT_TRIG, CAPTURE

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_en=0, wr_addr=0, wr_data=0, disp_bank=0, frame_done=0, busy=0; all internal counters and flags cleared.
- States are IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD.
- IDLE: if run=1, go to ARM next cycle. On that entry, latch trig_level, trig_falling and decim. Later changes to these inputs have no effect until the next ARM.
- ARM: the first sample_valid stores sample as prev and moves to WAIT_TRIG. No trigger is evaluated in ARM.
- WAIT_TRIG: on every sample_valid, evaluate the trigger against the latched values (no decimation applied):
  - rising: prev < level && sample >= level
  - falling: prev > level && sample <= level
  - prev is updated with sample on every sample_valid.
  - A pending force flag is set by force_trig and cleared on use. If force is pending, or force_trig arrives together with sample_valid, that sample triggers.
- Trigger: the triggering sample is written at address 0. The decimation counter is cleared. Go to CAPTURE.
- CAPTURE: each sample_valid advances the decimation counter. When the counter reaches decim, write the sample at the next address and reset the counter. With decim=0, every sample is written.
- Write timing: wr_en, wr_addr and wr_data are registered, with 1-cycle latency after the accepted sample_valid. wr_en is a single-cycle pulse per write.
- Frame end: after the write to address DEPTH-1, on the following cycle frame_done=1 and disp_bank toggles; wr_bank follows as ~disp_bank. Then:
  - single=1: go to HOLD.
  - otherwise: go to ARM; the next frame re-arms immediately and waits for a fresh trigger edge.
- HOLD: remain until run=0, then go to IDLE.
- Abort: run=0 in ARM, WAIT_TRIG or CAPTURE goes to IDLE next cycle. A partial frame is discarded: no frame_done, no bank swap, and no writes after the cycle where run=0 is seen.
- Addresses never exceed DEPTH-1; the address counter resets to 0 at every trigger.
- sample_valid in IDLE or HOLD is ignored. force_trig outside WAIT_TRIG is ignored and does not set the flag.
- busy = (state is ARM, WAIT_TRIG or CAPTURE), registered.

Optional Feature:
Macro TRIGGER_CAPTURE_CTRL_AUTO_TRIG_EN.
- Defined: a cycle counter runs while in WAIT_TRIG and clears on leaving WAIT_TRIG. When it reaches AUTO_TIMEOUT-1 with auto_mode=1, it sets the force flag, so the next sample triggers and a free-running trace appears with no signal edge.
- Not defined: the counter is not built and auto_mode is ignored. WAIT_TRIG waits indefinitely for an edge or force_trig.

Test Plan:
1. Reset with rst_n=0 mid-CAPTURE:
   - Outputs return to 0 and state to IDLE asynchronously.
   - After release with run=0, no wr_en pulses occur.
2. Ramp 0..1023 repeating, one sample every 4 clks; level=512, rising, decim=0, continuous:
   - First write is addr 0, data 512; addr 639 gets data 127.
   - frame_done pulses once, 1 cycle after that write; disp_bank goes 0→1.
3. Same ramp with decim=3:
   - addr 0 data 512, addr 1 data 516, addr 639 data (512+2556)%1024=1020.
   - Exactly 640 wr_en pulses.
4. Falling trigger, level=200, samples 300,250,200:
   - Trigger fires on 200, not on 250; the first write is data 200.
5. Constant sample 100, level 512:
   - No trigger occurs.
   - force_trig pulse → next sample is written at addr 0.
   - With single=1, after frame_done the block stays in HOLD and busy=0.
6. run dropped after 300 writes:
   - No frame_done and disp_bank unchanged.
   - With AUTO_TRIG_EN, AUTO_TIMEOUT=100, auto_mode=1, and a constant input, a trigger occurs within 100 clks plus one sample period.

Source files
------------

// File: rtl/trigger_capture_ctrl.sv
// trigger_capture_ctrl: arms, detects a level-crossing trigger and writes one decimated frame into a double-buffered RAM.
// Optional auto-trigger timeout is built when TRIGGER_CAPTURE_CTRL_AUTO_TRIG_EN is defined.
module trigger_capture_ctrl #(
  parameter int DATA_W       = 10,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int DECIM_W      = 8,
  parameter int AUTO_TIMEOUT = 2_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              single,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic [DECIM_W-1:0] decim,
  input  logic              force_trig,
  input  logic              auto_mode,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] level_q, level_d, prev_q, prev_d, wr_data_q, wr_data_d;
  logic [DECIM_W-1:0] decim_q, decim_d, dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic falling_q, falling_d, force_q, force_d, pend_q, pend_d;
  logic disp_bank_q, disp_bank_d, wr_en_q, wr_en_d, frame_done_q, frame_done_d, busy_q, busy_d;
  logic edge_hit, auto_fire;
  assign edge_hit = falling_q ? (prev_q > level_q && sample <= level_q)
                              : (prev_q < level_q && sample >= level_q);
`ifdef TRIGGER_CAPTURE_CTRL_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign auto_fire = state_q == WAIT_TRIG && auto_mode && tmo_q == TW'(AUTO_TIMEOUT - 1);
  assign tmo_d = (state_q == WAIT_TRIG && state_d == WAIT_TRIG && !auto_fire) ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  logic unused_auto;
  assign unused_auto = auto_mode;
  assign auto_fire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    falling_d = falling_q;
    decim_d = decim_q;
    prev_d = prev_q;
    dcnt_d = dcnt_q;
    addr_d = addr_q;
    pend_d = pend_q;
    force_d = 1'b0;
    disp_bank_d = disp_bank_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (run) begin
        state_d = ARM;
        level_d = trig_level;
        falling_d = trig_falling;
        decim_d = decim;
      end
      ARM: if (!run) state_d = IDLE;
      else if (sample_valid) begin
        prev_d = sample;
        state_d = WAIT_TRIG;
      end
      WAIT_TRIG: if (!run) state_d = IDLE;
      else begin
        force_d = force_q || force_trig || auto_fire;
        if (sample_valid) begin
          prev_d = sample;
          if (force_q || force_trig || edge_hit) begin
            force_d = 1'b0;
            wr_en_d = 1'b1;
            wr_addr_d = '0;
            wr_data_d = sample;
            addr_d = ADDR_W'(1);
            dcnt_d = '0;
            pend_d = (DEPTH == 1);
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: if (!run) begin
        state_d = IDLE;
        pend_d = 1'b0;
      end else if (pend_q) begin
        // last write is on the bus this cycle; swap banks only now
        pend_d = 1'b0;
        frame_done_d = 1'b1;
        disp_bank_d = ~disp_bank_q;
        state_d = single ? HOLD : ARM;
      end else if (sample_valid) begin
        if (dcnt_q == decim_q) begin
          dcnt_d = '0;
          wr_en_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = sample;
          addr_d = addr_q + 1'b1;
          pend_d = addr_q == ADDR_W'(DEPTH - 1);
        end else dcnt_d = dcnt_q + 1'b1;
      end
      HOLD: if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {ARM, WAIT_TRIG, CAPTURE};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      falling_q <= 1'b0;
      decim_q <= '0;
      prev_q <= '0;
      dcnt_q <= '0;
      addr_q <= '0;
      pend_q <= 1'b0;
      force_q <= 1'b0;
      disp_bank_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frame_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      falling_q <= falling_d;
      decim_q <= decim_d;
      prev_q <= prev_d;
      dcnt_q <= dcnt_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      force_q <= force_d;
      disp_bank_q <= disp_bank_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q <= busy_d;
    end
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign disp_bank = disp_bank_q;
  assign wr_bank = ~disp_bank_q;
  assign frame_done = frame_done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// tb_trigger_capture_ctrl: directed checks of trigger, decimation, frame swap, abort and reset behaviour.
module tb_trigger_capture_ctrl;
  logic clk = 0, rst_n = 0, run = 0, single = 0, sample_valid = 0;
  logic trig_falling = 0, force_trig = 0, auto_mode = 0;
  logic [9:0] sample = 0, trig_level = 0;
  logic [7:0] decim = 0;
  logic wr_en, wr_bank, disp_bank, frame_done, busy;
  logic [9:0] wr_addr, wr_data;
  int cyc = 0, nwr = 0, nfd = 0, fd_cyc = 0;
  logic [9:0] wlog_a [4096];
  logic [9:0] wlog_d [4096];
  int wlog_c [4096];
  int checks = 0, fails = 0;
  int b, f;
  trigger_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .single(single),
    .sample_valid(sample_valid), .sample(sample), .trig_level(trig_level),
    .trig_falling(trig_falling), .decim(decim), .force_trig(force_trig),
    .auto_mode(auto_mode), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .disp_bank(disp_bank), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (wr_en === 1'b1) begin
      if (nwr < 4096) begin
        wlog_a[nwr] = wr_addr;
        wlog_d[nwr] = wr_data;
        wlog_c[nwr] = cyc;
      end
      nwr++;
    end
    if (frame_done === 1'b1) begin
      nfd++;
      fd_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [9:0] v);
    @(negedge clk);
    sample = v;
    sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    wait_n(2);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_disp_bank", disp_bank, 0);
    chk("rst_wr_bank", wr_bank, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1;
    wait_n(2);
    chk("idle_busy", busy, 0);
    // rising ramp, decim 0, continuous
    trig_level = 512; trig_falling = 0; decim = 0; single = 0; run = 1;
    wait_n(2);
    chk("t2_busy", busy, 1);
    b = nwr; f = nfd;
    for (int i = 0; i < 2000 && nfd == f; i++) send(10'(i % 1024));
    wait_n(3);
    chk("t2_nwr", nwr - b, 640);
    chk("t2_first_addr", wlog_a[b], 0);
    chk("t2_first_data", wlog_d[b], 512);
    chk("t2_last_addr", wlog_a[b+639], 639);
    chk("t2_last_data", wlog_d[b+639], 127);
    chk("t2_nfd", nfd - f, 1);
    chk("t2_fd_latency", fd_cyc - wlog_c[b+639], 1);
    chk("t2_disp_bank", disp_bank, 1);
    chk("t2_wr_bank", wr_bank, 0);
    run = 0;
    wait_n(3);
    chk("t2_stop_busy", busy, 0);
    // decim 3; input changes after arming must be ignored
    decim = 3; run = 1;
    wait_n(2);
    decim = 7; trig_level = 100;
    b = nwr; f = nfd;
    for (int i = 0; i < 4000 && nfd == f; i++) send(10'(i % 1024));
    wait_n(3);
    chk("t3_nwr", nwr - b, 640);
    chk("t3_d0", wlog_d[b], 512);
    chk("t3_a1", wlog_a[b+1], 1);
    chk("t3_d1", wlog_d[b+1], 516);
    chk("t3_d639", wlog_d[b+639], 1020);
    chk("t3_nfd", nfd - f, 1);
    chk("t3_disp_bank", disp_bank, 0);
    run = 0;
    wait_n(3);
    // constant input, force trigger, single shot
    trig_level = 512; trig_falling = 0; decim = 0; single = 1; run = 1;
    wait_n(2);
    b = nwr; f = nfd;
    for (int i = 0; i < 6; i++) send(100);
    wait_n(1);
    chk("t5_no_trig", nwr - b, 0);
    chk("t5_busy_wait", busy, 1);
    @(negedge clk) force_trig = 1;
    @(negedge clk) force_trig = 0;
    send(100);
    wait_n(1);
    chk("t5_force_nwr", nwr - b, 1);
    chk("t5_force_addr", wlog_a[b], 0);
    chk("t5_force_data", wlog_d[b], 100);
    for (int i = 0; i < 700 && nfd == f; i++) send(100);
    wait_n(3);
    chk("t5_nwr", nwr - b, 640);
    chk("t5_nfd", nfd - f, 1);
    chk("t5_disp_bank", disp_bank, 1);
    chk("t5_hold_busy", busy, 0);
    for (int i = 0; i < 5; i++) send(600);
    wait_n(1);
    chk("t5_hold_nwr", nwr - b, 640);
    run = 0;
    wait_n(3);
    // falling trigger at 200
    trig_level = 200; trig_falling = 1; single = 1; run = 1;
    wait_n(2);
    b = nwr; f = nfd;
    send(300);
    send(250);
    wait_n(1);
    chk("t4_no_trig_250", nwr - b, 0);
    send(200);
    wait_n(1);
    chk("t4_nwr", nwr - b, 1);
    chk("t4_data", wlog_d[b], 200);
    run = 0;
    wait_n(3);
    chk("t4_abort_nfd", nfd - f, 0);
    chk("t4_abort_bank", disp_bank, 1);
    // abort after 300 writes
    trig_level = 512; trig_falling = 0; single = 0; run = 1;
    wait_n(2);
    b = nwr; f = nfd;
    for (int i = 0; i < 2000 && nwr - b < 300; i++) send(10'(i % 1024));
    run = 0;
    for (int i = 0; i < 10; i++) send(10'(i));
    wait_n(3);
    chk("t6_nwr", nwr - b, 300);
    chk("t6_nfd", nfd - f, 0);
    chk("t6_disp_bank", disp_bank, 1);
    chk("t6_busy", busy, 0);
    // asynchronous reset mid-capture
    run = 1;
    wait_n(2);
    b = nwr;
    for (int i = 0; i < 2000 && nwr - b < 50; i++) send(10'(i % 1024));
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t1_wr_en", wr_en, 0);
    chk("t1_wr_addr", wr_addr, 0);
    chk("t1_wr_data", wr_data, 0);
    chk("t1_busy", busy, 0);
    chk("t1_disp_bank", disp_bank, 0);
    chk("t1_frame_done", frame_done, 0);
    run = 0;
    wait_n(2);
    rst_n = 1;
    b = nwr;
    for (int i = 0; i < 20; i++) send(10'(500 + i));
    wait_n(2);
    chk("t1_no_writes", nwr - b, 0);
    chk("t1_idle_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
